// File: rtl/chassis_odo_pkg.sv
// chassis_odo_pkg
//   Shared types and helpers for the wheel odometry front end.
//   - CNT_W / DLT_W        : running-count and per-window delta widths
//   - SAT_MAX / SAT_MIN    : delta clamp limits
//   - step_e               : decoded quadrature step (none / +1 / -1 / illegal)
//   - qei_decode()         : 4x Gray-code decode of prev -> curr {A,B}
//   - sat_delta()          : clamp a 32-bit modular difference to 16 bits
package chassis_odo_pkg;

    localparam int CNT_W = 32;
    localparam int DLT_W = 16;

    localparam logic signed [DLT_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DLT_W-1:0] SAT_MIN = 16'sh8000;

    // Clamp limits sign-extended to count width for comparison.
    localparam logic signed [CNT_W-1:0] SAT_MAX_W = 32'sd32767;
    localparam logic signed [CNT_W-1:0] SAT_MIN_W = -32'sd32768;

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_INC  = 2'b01,
        STEP_DEC  = 2'b10,
        STEP_ERR  = 2'b11
    } step_e;

    // Position of {A,B} along the forward sequence 00 -> 01 -> 11 -> 10.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    // A position difference of 2 means both bits flipped: direction unknown.
    function automatic step_e qei_decode(input logic [1:0] prev_ab,
                                         input logic [1:0] curr_ab);
        logic [1:0] diff;
        diff = gray_pos(curr_ab) - gray_pos(prev_ab);
        case (diff)
            2'd0:    return STEP_NONE;
            2'd1:    return STEP_INC;
            2'd3:    return STEP_DEC;
            default: return STEP_ERR;
        endcase
    endfunction

    // Input is a modular 32-bit difference, so accumulator wrap is already
    // folded out before the clamp.
    function automatic logic [DLT_W-1:0] sat_delta(input logic [CNT_W-1:0] diff);
        logic signed [CNT_W-1:0] d;
        d = $signed(diff);
        if (d > SAT_MAX_W)      return SAT_MAX;
        else if (d < SAT_MIN_W) return SAT_MIN;
        else                    return diff[DLT_W-1:0];
    endfunction

endpackage

// File: rtl/qei_channel.sv
// qei_channel
//   One quadrature channel: 2-FF synchroniser, optional glitch filter,
//   4x decode, signed 32-bit wrapping accumulator and sticky error flag.
//   Build option: QEI_FILTER_EN adds a per-input stability filter of
//   FILT_LEN cycles between synchroniser and decoder.
// Ports
//   clk, rst_n  clock, async active-low reset
//   enc_a/enc_b raw encoder inputs (asynchronous)
//   clr         sync clear of accumulator, error flag and priming
//   acc_next    accumulator value including this cycle's step
//   err         sticky illegal-transition flag
module qei_channel
    import chassis_odo_pkg::*;
#(
    parameter int FILT_LEN = 4,
    parameter bit DIR      = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr,
    output logic [CNT_W-1:0] acc_next,
    output logic             err
);

    logic [1:0]       sync1, sync2;
    logic [1:0]       cur_ab;
    logic [1:0]       prev_ab;
    logic             primed;
    logic [CNT_W-1:0] acc;
    step_e            step;
    logic [CNT_W-1:0] step_val;

    // A filter shorter than one cycle has no meaning; refuse to elaborate.
    if (FILT_LEN < 1) begin : g_filt_len_invalid
        filt_len_must_be_positive u_bad ();
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
        end
    end

`ifdef QEI_FILTER_EN
    localparam int FCW = $clog2(FILT_LEN + 1);

    logic [1:0]          filt_q;
    logic [1:0][FCW-1:0] stab_cnt;

    // A bit's filtered value follows the synchronised value only after
    // FILT_LEN consecutive samples that disagree with the current output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q   <= '0;
            stab_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt_q[i]) begin
                    stab_cnt[i] <= '0;
                end else if (stab_cnt[i] == FCW'(FILT_LEN - 1)) begin
                    filt_q[i]   <= sync2[i];
                    stab_cnt[i] <= '0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign cur_ab = filt_q;
`else
    assign cur_ab = sync2;
`endif

    // Unprimed: the first sample only establishes the reference state.
    assign step = primed ? qei_decode(prev_ab, cur_ab) : STEP_NONE;

    always_comb begin
        step_val = '0;
        case (step)
            STEP_INC: step_val = DIR ? '1 : CNT_W'(1);
            STEP_DEC: step_val = DIR ? CNT_W'(1) : '1;
            default:  step_val = '0;
        endcase
    end

    assign acc_next = acc + step_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            err     <= 1'b0;
            primed  <= 1'b0;
            prev_ab <= '0;
        end else if (clr) begin
            acc     <= '0;
            err     <= 1'b0;
            primed  <= 1'b0;
            prev_ab <= '0;
        end else begin
            primed  <= 1'b1;
            prev_ab <= cur_ab;
            acc     <= acc_next;
            if (step == STEP_ERR) err <= 1'b1;
        end
    end

endmodule

// File: rtl/wheel_odometry_counter.sv
// wheel_odometry_counter
//   Dual-channel quadrature front end: decodes left/right encoders, keeps
//   signed 32-bit counts, snapshots them on sample_tick and reports
//   saturated 16-bit deltas per window.
//   Build option: QEI_FILTER_EN enables the input stability filter
//   (FILT_LEN cycles) in each channel.
// Ports
//   clk, rst_n          clock, async active-low reset
//   enc_l_a/b, enc_r_a/b encoder inputs (asynchronous)
//   clr                 sync clear of counts, deltas and error flags
//   sample_tick         one-cycle snapshot request
//   left_count          signed left snapshot (y_Global)
//   right_count         signed right snapshot (x_Global)
//   delta_l, delta_r    signed saturated change since previous snapshot
//   count_valid         one-cycle pulse when snapshot/deltas update
//   err_l, err_r        sticky illegal-transition flags
module wheel_odometry_counter
    import chassis_odo_pkg::*;
#(
    parameter int FILT_LEN = 4,
    parameter bit DIR_L    = 1'b0,
    parameter bit DIR_R    = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enc_l_a,
    input  logic                    enc_l_b,
    input  logic                    enc_r_a,
    input  logic                    enc_r_b,
    input  logic                    clr,
    input  logic                    sample_tick,
    output logic signed [CNT_W-1:0] left_count,
    output logic signed [CNT_W-1:0] right_count,
    output logic signed [DLT_W-1:0] delta_l,
    output logic signed [DLT_W-1:0] delta_r,
    output logic                    count_valid,
    output logic                    err_l,
    output logic                    err_r
);

    // Channel 0 = left, channel 1 = right.
    localparam int NUM_CH = 2;

    logic [NUM_CH-1:0]            enc_a, enc_b, err_ch;
    logic [NUM_CH-1:0][CNT_W-1:0] acc_next;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_CH-1:0][DLT_W-1:0] dlt_q;

    assign enc_a = {enc_r_a, enc_l_a};
    assign enc_b = {enc_r_b, enc_l_b};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        qei_channel #(
            .FILT_LEN (FILT_LEN),
            .DIR      ((ch == 0) ? DIR_L : DIR_R)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .enc_a    (enc_a[ch]),
            .enc_b    (enc_b[ch]),
            .clr      (clr),
            .acc_next (acc_next[ch]),
            .err      (err_ch[ch])
        );
    end

    // Snapshot takes acc_next so a step landing on the tick cycle is included.
    // clr wins over the snapshot but the tick still produces a valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            dlt_q       <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= sample_tick;
            if (clr) begin
                cnt_q <= '0;
                dlt_q <= '0;
            end else if (sample_tick) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    cnt_q[ch] <= acc_next[ch];
                    dlt_q[ch] <= sat_delta(acc_next[ch] - cnt_q[ch]);
                end
            end
        end
    end

    assign left_count  = cnt_q[0];
    assign right_count = cnt_q[1];
    assign delta_l     = dlt_q[0];
    assign delta_r     = dlt_q[1];
    assign err_l       = err_ch[0];
    assign err_r       = err_ch[1];

endmodule

// File: tb/tb_wheel_odometry_counter.sv
// Self-checking bench for wheel_odometry_counter. Expected snapshots are
// computed from a behavioural encoder model and queued at each tick; the
// monitor pops one entry per count_valid pulse.
module tb_wheel_odometry_counter;

    localparam bit DIR_L    = 1'b0;
    localparam bit DIR_R    = 1'b1;
    localparam int FILT_LEN = 4;
`ifdef QEI_FILTER_EN
    localparam int HOLD = FILT_LEN + 2;
    localparam int LAT  = 2 + FILT_LEN;
`else
    localparam int HOLD = 1;
    localparam int LAT  = 2;
`endif
    localparam int SETTLE = LAT + 3;

    logic               clk, rst_n;
    logic               enc_l_a, enc_l_b, enc_r_a, enc_r_b;
    logic               clr, sample_tick;
    logic signed [31:0] left_count, right_count;
    logic signed [15:0] delta_l, delta_r;
    logic               count_valid, err_l, err_r;

    wheel_odometry_counter #(
        .FILT_LEN (FILT_LEN),
        .DIR_L    (DIR_L),
        .DIR_R    (DIR_R)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enc_l_a     (enc_l_a),
        .enc_l_b     (enc_l_b),
        .enc_r_a     (enc_r_a),
        .enc_r_b     (enc_r_b),
        .clr         (clr),
        .sample_tick (sample_tick),
        .left_count  (left_count),
        .right_count (right_count),
        .delta_l     (delta_l),
        .delta_r     (delta_r),
        .count_valid (count_valid),
        .err_l       (err_l),
        .err_r       (err_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic [15:0] dl;
        logic [15:0] dr;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          pos[2];
    logic [31:0] m_acc[2];
    logic [31:0] m_cnt[2];

    function automatic logic [1:0] gray(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [15:0] m_sat(input logic [31:0] d);
        int s;
        s = $signed(d);
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return d[15:0];
    endfunction

    task automatic drive_enc();
        {enc_l_a, enc_l_b} = gray(pos[0]);
        {enc_r_a, enc_r_b} = gray(pos[1]);
    endtask

    task automatic step(input int ch, input int dir);
        logic neg;
        @(negedge clk);
        pos[ch] = (pos[ch] + dir) & 3;
        drive_enc();
        neg = (dir < 0) ^ ((ch == 0) ? DIR_L : DIR_R);
        m_acc[ch] = m_acc[ch] + (neg ? 32'hFFFF_FFFF : 32'd1);
        repeat (HOLD - 1) @(negedge clk);
    endtask

    task automatic settle();
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic push_exp(input bit with_clr);
        exp_t e;
        if (with_clr) begin
            for (int c = 0; c < 2; c++) begin
                m_acc[c] = '0;
                m_cnt[c] = '0;
            end
        end
        e.l  = m_acc[0];
        e.r  = m_acc[1];
        e.dl = m_sat(m_acc[0] - m_cnt[0]);
        e.dr = m_sat(m_acc[1] - m_cnt[1]);
        m_cnt[0] = m_acc[0];
        m_cnt[1] = m_acc[1];
        sb.push_back(e);
    endtask

    task automatic check_drained(input string name);
        n_vec++;
        if (sb.size() !== 0) begin
            n_err++;
            $display("FAIL %s: %0d snapshots pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_tick(input bit with_clr, input string name);
        @(negedge clk);
        sample_tick = 1'b1;
        clr         = with_clr;
        push_exp(with_clr);
        @(negedge clk);
        sample_tick = 1'b0;
        clr         = 1'b0;
        @(negedge clk);
        check_drained(name);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        for (int c = 0; c < 2; c++) begin
            m_acc[c] = '0;
            m_cnt[c] = '0;
        end
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Monitor: every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && count_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: count_valid=1, required 0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_vec++;
                if (left_count !== e.l) begin
                    n_err++;
                    $display("FAIL left_count: got %h, required %h", left_count, e.l);
                end
                n_vec++;
                if (right_count !== e.r) begin
                    n_err++;
                    $display("FAIL right_count: got %h, required %h", right_count, e.r);
                end
                n_vec++;
                if (delta_l !== e.dl) begin
                    n_err++;
                    $display("FAIL delta_l: got %h, required %h", delta_l, e.dl);
                end
                n_vec++;
                if (delta_r !== e.dr) begin
                    n_err++;
                    $display("FAIL delta_r: got %h, required %h", delta_r, e.dr);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; sample_tick = 1'b0;
        pos[0] = 0; pos[1] = 0;
        for (int c = 0; c < 2; c++) begin
            m_acc[c] = '0;
            m_cnt[c] = '0;
        end
        drive_enc();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({left_count, right_count} !== 64'd0) begin
            n_err++;
            $display("FAIL reset_counts: got %h/%h, required 0/0", left_count, right_count);
        end
        n_vec++;
        if ({delta_l, delta_r} !== 32'd0) begin
            n_err++;
            $display("FAIL reset_deltas: got %h/%h, required 0/0", delta_l, delta_r);
        end
        n_vec++;
        if ({count_valid, err_l, err_r} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got %b, required 000", {count_valid, err_l, err_r});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_left_fwd();
        repeat (8) step(0, 1);
        settle();
        do_tick(1'b0, "left_fwd_valid");
    endtask

    task automatic test_right_dir();
        repeat (5) step(1, 1);
        settle();
        do_tick(1'b0, "right_dir_valid");
    endtask

    task automatic test_illegal_and_clr();
        @(negedge clk);
        pos[0] = (pos[0] + 2) & 3;   // both bits flip: no count
        drive_enc();
        settle();
        n_vec++;
        if ({err_l, err_r} !== 2'b10) begin
            n_err++;
            $display("FAIL err_flags: got %b, required 10", {err_l, err_r});
        end
        do_tick(1'b0, "illegal_valid");
        do_clr();
        n_vec++;
        if ({left_count, right_count, delta_l, delta_r} !== 96'd0) begin
            n_err++;
            $display("FAIL clr_outputs: got %h %h %h %h, required 0", left_count, right_count, delta_l, delta_r);
        end
        n_vec++;
        if ({err_l, err_r} !== 2'b00) begin
            n_err++;
            $display("FAIL clr_err: got %b, required 00", {err_l, err_r});
        end
        settle();
    endtask

    // A step whose decode lands on the clr cycle is lost; counting resumes after.
    task automatic test_clr_race();
        repeat (3) step(0, 1);
        settle();
        @(negedge clk);
        pos[0] = (pos[0] + 1) & 3;
        drive_enc();
        repeat (LAT) @(negedge clk);
        clr = 1'b1;
        for (int c = 0; c < 2; c++) begin
            m_acc[c] = '0;
            m_cnt[c] = '0;
        end
        @(negedge clk);
        clr = 1'b0;
        settle();
        do_tick(1'b0, "clr_race_valid");
        repeat (2) step(0, 1);
        settle();
        do_tick(1'b0, "clr_resume_valid");
    endtask

    task automatic test_back_to_back();
        repeat (3) step(0, -1);
        repeat (2) step(1, 1);
        settle();
        @(negedge clk);
        sample_tick = 1'b1;
        push_exp(1'b0);
        @(negedge clk);
        push_exp(1'b0);
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        check_drained("back_to_back_valid");
    endtask

    task automatic test_clr_tick();
        repeat (4) step(0, 1);
        repeat (4) step(1, -1);
        settle();
        do_tick(1'b1, "clr_tick_valid");
        settle();
    endtask

    task automatic test_wrap();
        settle();
        @(negedge clk);
        force dut.g_ch[0].u_ch.acc = 32'h7FFF_FFFE;
        @(negedge clk);
        release dut.g_ch[0].u_ch.acc;
        m_acc[0] = 32'h7FFF_FFFE;
        do_tick(1'b0, "wrap_preload_valid");
        repeat (3) step(0, 1);
        settle();
        do_tick(1'b0, "wrap_valid");
    endtask

`ifndef QEI_FILTER_EN
    task automatic test_saturation();
        do_clr();
        settle();
        for (int i = 0; i < 40000; i++) step(0, 1);
        settle();
        do_tick(1'b0, "sat_valid");
    endtask
`endif

`ifdef QEI_FILTER_EN
    task automatic test_filter();
        settle();
        @(negedge clk);
        enc_l_a = ~enc_l_a;          // 2-cycle glitch, must be suppressed
        repeat (2) @(negedge clk);
        drive_enc();
        settle();
        do_tick(1'b0, "glitch_valid");
        step(0, 1);                  // held HOLD (6) cycles, must count
        settle();
        do_tick(1'b0, "filter_level_valid");
    endtask
`endif

    initial begin
        test_reset();
        test_left_fwd();
        test_right_dir();
        test_illegal_and_clr();
        test_clr_race();
        test_back_to_back();
        test_clr_tick();
        test_wrap();
`ifndef QEI_FILTER_EN
        test_saturation();
`else
        test_filter();
`endif
        repeat (3) @(negedge clk);
        check_drained("final_drain");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
